// File: rtl/id_instr_decode.sv
// RV32I decode stage with a one-entry output register and accept/illegal counters.
// Illegal words leave the pipeline as a marked bundle so that a later stage can raise the trap.
module id_instr_decode #(
  parameter bit ILLEGAL_AS_NOP = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic        i_flush,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [6:0]  o_op,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [31:0] o_imm,
  output logic [31:0] o_pc,
  output logic        o_illegal,
  output logic [31:0] o_instr_count,
  output logic [15:0] o_illegal_count
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] OP_ILLEGAL = 7'd127;
  localparam logic [6:0] OP_ADDI    = 7'd30;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_fld_rd;
  logic [4:0]  w_fld_rs1;
  logic [4:0]  w_fld_rs2;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_sh;

  assign w_opc     = i_instr[6:0];
  assign w_f3      = i_instr[14:12];
  assign w_f7      = i_instr[31:25];
  assign w_fld_rd  = i_instr[11:7];
  assign w_fld_rs1 = i_instr[19:15];
  assign w_fld_rs2 = i_instr[24:20];

  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u  = {i_instr[31:12], 12'h000};
  assign w_imm_j  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  assign w_imm_sh = {27'd0, i_instr[24:20]};

  // Raw decode: fields are filled per format; w_legal gates whether they survive.
  logic [6:0]  w_op;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_imm;
  logic        w_legal;

  always_comb begin
    w_op    = OP_ILLEGAL;
    w_rd    = '0;
    w_rs1   = '0;
    w_rs2   = '0;
    w_imm   = '0;
    w_legal = 1'b0;
    case (w_opc)
      OPC_LUI: begin
        w_op = 7'd0; w_rd = w_fld_rd; w_imm = w_imm_u; w_legal = 1'b1;
      end
      OPC_AUIPC: begin
        w_op = 7'd1; w_rd = w_fld_rd; w_imm = w_imm_u; w_legal = 1'b1;
      end
      OPC_JAL: begin
        w_op = 7'd2; w_rd = w_fld_rd; w_imm = w_imm_j; w_legal = 1'b1;
      end
      OPC_JALR: begin
        w_op = 7'd3; w_rd = w_fld_rd; w_rs1 = w_fld_rs1; w_imm = w_imm_i;
        w_legal = (w_f3 == 3'b000);
      end
      OPC_BRANCH: begin
        w_rs1 = w_fld_rs1; w_rs2 = w_fld_rs2; w_imm = w_imm_b;
        w_legal = 1'b1;
        case (w_f3)
          3'b000:  w_op = 7'd10;
          3'b001:  w_op = 7'd11;
          3'b100:  w_op = 7'd12;
          3'b101:  w_op = 7'd13;
          3'b110:  w_op = 7'd14;
          3'b111:  w_op = 7'd15;
          default: w_legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        w_op = 7'd20; w_rd = w_fld_rd; w_rs1 = w_fld_rs1; w_imm = w_imm_i;
        w_legal = (w_f3 == 3'b010);
      end
      OPC_STORE: begin
        w_op = 7'd21; w_rs1 = w_fld_rs1; w_rs2 = w_fld_rs2; w_imm = w_imm_s;
        w_legal = (w_f3 == 3'b010);
      end
      OPC_OPIMM: begin
        w_rd = w_fld_rd; w_rs1 = w_fld_rs1; w_imm = w_imm_i;
        w_legal = 1'b1;
        case (w_f3)
          3'b000: w_op = 7'd30;
          3'b010: w_op = 7'd31;
          3'b011: w_op = 7'd32;
          3'b100: w_op = 7'd33;
          3'b110: w_op = 7'd34;
          3'b111: w_op = 7'd35;
          3'b001: begin
            w_op = 7'd36; w_imm = w_imm_sh; w_legal = (w_f7 == F7_ZERO);
          end
          default: begin
            w_op = (w_f7 == F7_ALT) ? 7'd38 : 7'd37;
            w_imm = w_imm_sh;
            w_legal = (w_f7 == F7_ZERO) || (w_f7 == F7_ALT);
          end
        endcase
      end
      OPC_OP: begin
        w_rd = w_fld_rd; w_rs1 = w_fld_rs1; w_rs2 = w_fld_rs2;
        w_legal = (w_f7 == F7_ZERO);
        case (w_f3)
          3'b000: begin
            w_op = (w_f7 == F7_ALT) ? 7'd41 : 7'd40;
            w_legal = (w_f7 == F7_ZERO) || (w_f7 == F7_ALT);
          end
          3'b001: w_op = 7'd42;
          3'b010: w_op = 7'd43;
          3'b011: w_op = 7'd44;
          3'b100: w_op = 7'd45;
          3'b101: begin
            w_op = (w_f7 == F7_ALT) ? 7'd47 : 7'd46;
            w_legal = (w_f7 == F7_ZERO) || (w_f7 == F7_ALT);
          end
          3'b110: w_op = 7'd48;
          default: w_op = 7'd49;
        endcase
      end
      default: ;
    endcase
  end

  logic [6:0]  w_b_op;
  logic [4:0]  w_b_rd;
  logic [4:0]  w_b_rs1;
  logic [4:0]  w_b_rs2;
  logic [31:0] w_b_imm;

  always_comb begin
    w_b_op  = w_op;
    w_b_rd  = w_rd;
    w_b_rs1 = w_rs1;
    w_b_rs2 = w_rs2;
    w_b_imm = w_imm;
    if (!w_legal) begin
      w_b_op  = ILLEGAL_AS_NOP ? OP_ADDI : OP_ILLEGAL;
      w_b_rd  = '0;
      w_b_rs1 = '0;
      w_b_rs2 = '0;
      w_b_imm = '0;
    end
  end

  // Handshake: a word moves on i_valid && o_ready; a bundle moves on o_valid && i_ready.
  // o_ready only passes i_ready through when the output register is full, and a flush
  // empties the register and blocks the incoming word without touching the counters.
  logic r_valid;
  logic w_accept;

  assign o_ready  = !r_valid || i_ready;
  assign w_accept = i_valid && o_ready && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid         <= 1'b0;
      o_op            <= '0;
      o_rd            <= '0;
      o_rs1           <= '0;
      o_rs2           <= '0;
      o_imm           <= '0;
      o_pc            <= '0;
      o_illegal       <= 1'b0;
      o_instr_count   <= '0;
      o_illegal_count <= '0;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid       <= 1'b1;
        o_op          <= w_b_op;
        o_rd          <= w_b_rd;
        o_rs1         <= w_b_rs1;
        o_rs2         <= w_b_rs2;
        o_imm         <= w_b_imm;
        o_pc          <= i_pc;
        o_illegal     <= !w_legal;
        o_instr_count <= o_instr_count + 32'd1;
        if (!w_legal && (o_illegal_count != 16'hFFFF)) begin
          o_illegal_count <= o_illegal_count + 16'd1;
        end
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;

endmodule

// File: doc/id_instr_decode.md
ID_INSTR_DECODE -- requirements
Module: id_instr_decode

Interface
REQ-001 SHALL have parameter ILLEGAL_AS_NOP, default 0: when 1, illegal words are emitted as ADDI x0,x0,0 with o_illegal still asserted.
REQ-002 SHALL have port i_clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_valid, input, 1, upstream word valid.
REQ-005 SHALL have port o_ready, output, 1, decoder can accept this cycle.
REQ-006 SHALL have port i_instr, input, 32, RV32I instruction word.
REQ-007 SHALL have port i_pc, input, 32, address of i_instr.
REQ-008 SHALL have port i_flush, input, 1, discard held and incoming words.
REQ-009 SHALL have port o_valid, output, 1, decoded bundle valid.
REQ-010 SHALL have port i_ready, input, 1, downstream accepts bundle.
REQ-011 SHALL have ports o_op (7), o_rd (5), o_rs1 (5), o_rs2 (5), o_imm (32), o_pc (32), o_illegal (1): the decoded bundle.
REQ-012 SHALL have ports o_instr_count (32) and o_illegal_count (16), both outputs.

Function
REQ-013 o_op codes SHALL be: LUI 0, AUIPC 1, JAL 2, JALR 3, BEQ..BGEU 10..15, LW 20, SW 21, ADDI,SLTI,SLTIU,XORI,ORI,ANDI,SLLI,SRLI,SRAI 30..38, ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND 40..49; illegal 127.
REQ-014 o_ready SHALL equal !o_valid || i_ready (one-entry output register, combinational pass-through of downstream ready only).
REQ-015 Accept SHALL occur when i_valid && o_ready && !i_flush; the bundle SHALL appear on the next rising edge (latency 1) with o_valid=1.
REQ-016 When o_valid && !i_ready, all bundle outputs SHALL hold stable until the transfer.
REQ-017 When o_valid && i_ready and no accept, o_valid SHALL clear next edge; with accept, back-to-back bundles SHALL issue at 1 per cycle.
REQ-018 i_flush SHALL clear o_valid next edge, override accept, and leave counters unchanged.
REQ-019 Immediates: I-type sign-extend instr[31:20]; S-type sign-extend {instr[31:25],instr[11:7]}; B-type sign-extend {instr[31],instr[7],instr[30:25],instr[11:8],0}; U-type {instr[31:12],12'b0}; J-type sign-extend {instr[31],instr[19:12],instr[20],instr[30:21],0}; shifts zero-extend instr[24:20]; R-type 0.
REQ-020 Register fields not used by the format SHALL be 0 (U/J: rs1=rs2=0; I: rs2=0; S/B: rd=0).
REQ-021 Illegal SHALL be: unsupported opcode, unsupported funct3, funct7 other than 0000000 (or 0100000 for SUB/SRA/SRAI), JALR funct3!=0; word 0x00000000 is illegal.
REQ-022 Illegal bundle SHALL carry o_op=127, all other fields 0 except o_pc, o_illegal=1 (ILLEGAL_AS_NOP=1: o_op=30, fields 0).
REQ-023 o_instr_count SHALL increment by 1 per accept, wrapping 0xFFFFFFFF->0.
REQ-024 o_illegal_count SHALL increment per accepted illegal word and saturate at 0xFFFF.
REQ-025 o_pc SHALL be the i_pc captured with the word.

Reset
REQ-026 While i_rst_n=0: o_valid=0, o_op=0, o_rd=o_rs1=o_rs2=0, o_imm=0, o_pc=0, o_illegal=0, both counters 0, immediately and regardless of clock.
REQ-027 Reset asserted with a held bundle SHALL drop it; first accept is possible on the first rising edge after deassertion.

Verification
REQ-028 i_instr=0x00108093, i_pc=0 -> next edge o_op=30, rd=1, rs1=1, rs2=0, imm=1, o_instr_count=1.
REQ-029 i_instr=0xFE0086E3 (BEQ x1,x0,-20), i_pc=36 -> o_op=10, rs1=1, rs2=0, rd=0, imm=0xFFFFFFEC, o_pc=36.
REQ-030 i_instr=0x00ABF437 (LUI x8) with i_ready=0 for 3 cycles -> o_op=0, rd=8, imm=0x00ABF000 held stable, o_ready=0 while stalled.
REQ-031 i_instr=0x00000000 -> o_illegal=1, o_op=127, o_illegal_count=1; repeat to 0xFFFF -> further illegals leave it at 0xFFFF.
REQ-032 i_flush=1 with o_valid=1 and i_valid=1 -> next edge o_valid=0, o_instr_count unchanged.
REQ-033 i_rst_n low mid-stall -> o_valid and counters 0 at once; stream of 10 back-to-back words after release -> 10 bundles in 10 consecutive cycles, o_instr_count=10.
